// File: rtl/fofir_tap_sequencer.sv
// fofir_tap_sequencer
// Control stage in front of the FoFIR delay-register index unit and the
// DReg/MAC datapath. Each accepted activation runs one filter step:
//   IDLE -> SHIFT (rotate D0) -> WRITE (store sample, clear acc)
//        -> ITER (one MAC per visited tap) -> DONE (hold result handshake).
// Every output is decoded from registered state and counters (Moore).
//
// Optional build macro FOFIR_ZERO_SKIP_EN adds a tap_mask input. The ITER
// walk then visits only the taps whose weights are nonzero, and an all-zero
// mask goes from WRITE straight to DONE.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE and,
// once raised, stays high with out_partial unchanged until out_ready is seen.
// Nothing bypasses: an input offered during the output handshake cycle is
// taken in the following IDLE cycle.
module fofir_tap_sequencer #(
    parameter int nb_taps           = 5,
    parameter int width_current_tap = (nb_taps > 8 ? 4 : 3)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         index_update_en,
    output logic                         dreg_wr_en,
    output logic                         acc_clear,
    output logic                         mac_en,
    output logic [width_current_tap-1:0] current_tap,
    output logic                         out_partial,
    output logic                         busy
`ifdef FOFIR_ZERO_SKIP_EN
    ,
    input  logic [nb_taps-1:0]           tap_mask
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] ITER  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [width_current_tap-1:0] NB_TAPS_W = width_current_tap'(nb_taps);
    localparam logic [width_current_tap-1:0] LAST_TAP  = width_current_tap'(nb_taps - 1);

    logic [2:0]                   state;
    logic [width_current_tap-1:0] tap_q;
    // Activations accepted since reset, saturating at nb_taps.
    logic [width_current_tap-1:0] warm_q;

`ifdef FOFIR_ZERO_SKIP_EN
    logic [nb_taps-1:0]           mask_q;
    logic [width_current_tap-1:0] first_tap;
    logic [width_current_tap-1:0] next_tap;
    logic                         has_next;

    // Find the lowest set mask bit overall and the lowest set bit above the current tap.
    always_comb begin
        first_tap = '0;
        next_tap  = '0;
        has_next  = 1'b0;
        for (int k = nb_taps - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                first_tap = width_current_tap'(k);
                if (k > int'(tap_q)) begin
                    next_tap = width_current_tap'(k);
                    has_next = 1'b1;
                end
            end
        end
    end
`endif

    // State, tap walk and warm-up counter. Reset overrides everything,
    // so a step that is aborted never produces out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            tap_q  <= '0;
            warm_q <= '0;
`ifdef FOFIR_ZERO_SKIP_EN
            mask_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= SHIFT;
                        if (warm_q < NB_TAPS_W) begin
                            warm_q <= warm_q + 1'b1;
                        end
`ifdef FOFIR_ZERO_SKIP_EN
                        mask_q <= tap_mask;
`endif
                    end
                end
                SHIFT: begin
                    state <= WRITE;
                end
                WRITE: begin
`ifdef FOFIR_ZERO_SKIP_EN
                    if (mask_q == '0) begin
                        state <= DONE;
                        tap_q <= '0;
                    end else begin
                        state <= ITER;
                        tap_q <= first_tap;
                    end
`else
                    state <= ITER;
                    tap_q <= '0;
`endif
                end
                ITER: begin
`ifdef FOFIR_ZERO_SKIP_EN
                    if (has_next) begin
                        tap_q <= next_tap;
                    end else begin
                        tap_q <= '0;
                        state <= DONE;
                    end
`else
                    if (tap_q == LAST_TAP) begin
                        tap_q <= '0;
                        state <= DONE;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tap_q <= '0;
                end
            endcase
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        in_ready        = (state == IDLE);
        index_update_en = (state == SHIFT);
        dreg_wr_en      = (state == WRITE);
        acc_clear       = (state == WRITE);
        mac_en          = (state == ITER);
        current_tap     = (state == ITER) ? tap_q : '0;
        out_valid       = (state == DONE);
        out_partial     = (state == DONE) && (warm_q < NB_TAPS_W);
        busy            = (state != IDLE);
    end

endmodule

// File: tb/tb_fofir_tap_sequencer.sv
// Testbench for fofir_tap_sequencer.
// The reference model describes each filter step as a timeline. An accept
// queues one expected output vector per cycle (shift, write, one entry per
// visited tap), followed by a result hold that ends on out_ready.
module tb_fofir_tap_sequencer;

  localparam int NB = 5;
  localparam int W  = (NB > 8 ? 4 : 3);
  localparam int EW = 8 + W;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready;
  logic index_update_en, dreg_wr_en, acc_clear, mac_en, out_partial, busy;
  logic [W-1:0] current_tap;
`ifdef FOFIR_ZERO_SKIP_EN
  logic [NB-1:0] tap_mask;
`endif

  fofir_tap_sequencer #(.nb_taps(NB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .index_update_en(index_update_en),
    .dreg_wr_en(dreg_wr_en),
    .acc_clear(acc_clear),
    .mac_en(mac_en),
    .current_tap(current_tap),
    .out_partial(out_partial),
    .busy(busy)
`ifdef FOFIR_ZERO_SKIP_EN
    ,
    .tap_mask(tap_mask)
`endif
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  bit in_step = 0;
  int warm = 0;
  bit partial = 0;

  // Packs {in_ready,out_valid,out_partial,index_update_en,dreg_wr_en,acc_clear,mac_en,busy,current_tap}.
  function automatic logic [EW-1:0] mk(input bit ir, input bit ov, input bit op, input bit iu,
                                       input bit dw, input bit ac, input bit me, input bit bz,
                                       input int tap);
    logic [W-1:0] t;
    t = W'(tap);
    return {ir, ov, op, iu, dw, ac, me, bz, t};
  endfunction

  function automatic logic [EW-1:0] expected_now();
    if (!in_step) return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (exp_q.size() != 0) return exp_q[0];
    return mk(0, 1, partial, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, given the inputs applied for it.
  task automatic model_step(input bit r, input bit iv, input bit ordy, input logic [NB-1:0] mask);
    if (!r) begin
      exp_q.delete();
      in_step = 0;
      warm = 0;
    end else if (!in_step) begin
      if (iv) begin
        if (warm < NB) warm++;
        partial = (warm < NB);
        in_step = 1;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
        for (int t = 0; t < NB; t++)
          if (mask[t]) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, t));
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (ordy) begin
      in_step = 0;
    end
  endtask

  // Driver: check this cycle's outputs, then apply inputs for the next edge.
  task automatic cycle(input bit r, input bit iv, input bit ordy);
    logic [NB-1:0] mask;
    @(negedge clk);
    check_eq("out_vec", {in_ready, out_valid, out_partial, index_update_en, dreg_wr_en,
                         acc_clear, mac_en, busy, current_tap}, expected_now());
`ifdef FOFIR_ZERO_SKIP_EN
    mask = NB'($urandom_range(0, (1 << NB) - 1));
    if ($urandom_range(0, 5) == 0) mask = '0;
    tap_mask = mask;
`else
    mask = '1;
`endif
    rst_n = r;
    in_valid = iv;
    out_ready = ordy;
    model_step(r, iv, ordy, mask);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef FOFIR_ZERO_SKIP_EN
    tap_mask = '0;
`endif
    model_step(0, 0, 0, '0);
    @(posedge clk);
    cycle(0, 0, 0);

    // Single step from reset
    cycle(1, 0, 1);
    cycle(1, 1, 1);
    repeat (12) cycle(1, 0, 1);

    // Back-to-back steps through warm-up into saturation
    repeat (70) cycle(1, 1, 1);

    // Output backpressure with in_valid held high
    repeat (12) cycle(1, 1, 0);
    repeat (3) cycle(1, 1, 1);
    repeat (14) cycle(1, 0, 0);
    cycle(1, 1, 1);

    // Reset while the tap walk is at tap 2
    cycle(0, 0, 1);
    cycle(1, 1, 1);
    repeat (4) cycle(1, 0, 1);
    cycle(0, 0, 1);
    repeat (3) cycle(1, 0, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 79) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);

    cycle(1, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
